// File: rtl/dmem_mem_arbiter.sv
// Round-robin arbiter that lets two core dmem units share one fixed-latency,
// single-port main memory, with one transaction in flight at a time.
module dmem_mem_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        rq_rden,
    input  logic [1:0]        rq_wren,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic [1:0]        rq_ack,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       req;
    logic             sel;
    logic             rr_ptr;
    logic             op_wr;
    logic [CNT_W-1:0] wait_cnt;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        req        = rq_rden | rq_wren;
        sel        = (req == 2'b11) ? rr_ptr : req[1];
        state_next = state;
        case (state)
            S_IDLE:  if (req != 2'b00) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (wait_cnt == '0) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Outputs are registered: each one is loaded on the edge that enters the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rq_ack    <= 2'b00;
            rsp_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rden  <= 1'b0;
            mem_wren  <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
            rr_ptr    <= 1'b0;
            op_wr     <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (state_next == S_ISSUE) begin
                        // A write wins over a simultaneous read from the same core.
                        grant_id  <= sel;
                        op_wr     <= rq_wren[sel];
                        mem_addr  <= sel ? rq1_addr : rq0_addr;
                        mem_wdata <= sel ? rq1_wdata : rq0_wdata;
                        mem_wren  <= rq_wren[sel];
                        mem_rden  <= ~rq_wren[sel];
                        busy      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    mem_rden <= 1'b0;
                    mem_wren <= 1'b0;
                    wait_cnt <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end else begin
                        if (!op_wr) rsp_rdata <= mem_rdata;
                        rq_ack <= grant_id ? 2'b10 : 2'b01;
                    end
                end
                S_RESP: begin
                    rq_ack    <= 2'b00;
                    rr_ptr    <= ~grant_id;
                    grant_id  <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mem_arbiter.sv
// Directed bench for dmem_mem_arbiter: a behavioural memory answers strobes after
// MEM_LAT cycles, and a scoreboard pairs every ack with its expected core, data and cycle.
module tb_dmem_mem_arbiter;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    localparam logic [31:0] D_A1 = 32'h1111_AAAA;
    localparam logic [31:0] D_A2 = 32'h2222_BBBB;
    localparam logic [31:0] D_BE = 32'hDEAD_BEEF;

    logic              clk;
    logic              reset;
    logic [1:0]        rq_rden;
    logic [1:0]        rq_wren;
    logic [ADDR_W-1:0] rq0_addr;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq0_wdata;
    logic [DATA_W-1:0] rq1_wdata;
    logic [1:0]        rq_ack;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rden;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              grant_id;

    dmem_mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rq_rden  (rq_rden),
        .rq_wren  (rq_wren),
        .rq0_addr (rq0_addr),
        .rq1_addr (rq1_addr),
        .rq0_wdata(rq0_wdata),
        .rq1_wdata(rq1_wdata),
        .rq_ack   (rq_ack),
        .rsp_rdata(rsp_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rden (mem_rden),
        .mem_wren (mem_wren),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .grant_id (grant_id)
    );

    typedef struct {
        logic [1:0]  ack;
        logic [31:0] data;
        int          cyc;
        string       tag;
    } exp_t;

    typedef struct {
        int         due;
        logic [3:0] addr;
    } rd_t;

    exp_t        sb[$];
    rd_t         pend[$];
    logic [31:0] mem_arr[16];
    int          cyc;
    int          mcyc;
    int          n_cmp;
    int          n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Behavioural main memory: read data appears exactly MEM_LAT cycles after the strobe cycle.
    initial begin
        mem_rdata = '0;
        mcyc      = 0;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            if (!reset) pend.delete();
            if (mem_wren) mem_arr[mem_addr] = mem_wdata;
            if (mem_rden) pend.push_back('{mcyc + MEM_LAT, mem_addr});
            if (pend.size() > 0 && pend[0].due == mcyc) begin
                mem_rdata = mem_arr[pend[0].addr];
                void'(pend.pop_front());
            end else begin
                mem_rdata = 32'hBAD0_0000 | 32'(mcyc);
            end
        end
    end

    // Scoreboard consumer: every ack pulse must match the oldest expected completion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rq_ack !== 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 64'(rq_ack), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_ack"}, 64'(rq_ack), 64'(e.ack));
                    check({e.tag, "_rdata"}, 64'(rsp_rdata), 64'(e.data));
                    check({e.tag, "_ack_cycle"}, 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // One transaction from a lone requester: checks the ISSUE strobe, then the ack via the scoreboard.
    task automatic do_single(input logic core, input logic rd, input logic wr,
                             input logic [3:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_data, input string tag);
        int t0;
        t0 = cyc;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_addr"}, 64'(mem_addr), 64'd0);
        if (core) begin
            rq1_addr = addr; rq1_wdata = wdata;
        end else begin
            rq0_addr = addr; rq0_wdata = wdata;
        end
        rq_rden[core] = rd;
        rq_wren[core] = wr;
        sb.push_back('{core ? 2'b10 : 2'b01, exp_data, t0 + MEM_LAT + 2, tag});
        step();
        check({tag, "_issue_rden"}, 64'(mem_rden), 64'(rd & ~wr));
        check({tag, "_issue_wren"}, 64'(mem_wren), 64'(wr));
        check({tag, "_issue_addr"}, 64'(mem_addr), 64'(addr));
        check({tag, "_issue_grant"}, 64'(grant_id), 64'(core));
        if (wr) check({tag, "_issue_wdata"}, 64'(mem_wdata), 64'(wdata));
        step();
        check({tag, "_strobe_len"}, 64'({mem_rden, mem_wren}), 64'd0);
        check({tag, "_wait_addr"}, 64'(mem_addr), 64'(addr));
        steps(2);
        rq_rden = 2'b00;
        rq_wren = 2'b00;
        step();
        check({tag, "_back_idle"}, 64'({busy, rq_ack}), 64'd0);
    endtask

    initial begin
        int t0;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        for (int i = 0; i < 16; i++) mem_arr[i] = 32'h0;
        mem_arr[1] = D_A1;
        mem_arr[2] = D_A2;
        mem_arr[3] = D_BE;

        // Reset held with both cores requesting.
        reset     = 1'b0;
        rq_rden   = 2'b11;
        rq_wren   = 2'b00;
        rq0_addr  = 4'h1;
        rq1_addr  = 4'h2;
        rq0_wdata = '0;
        rq1_wdata = '0;
        steps(3);
        check("rst_ack", 64'(rq_ack), 64'd0);
        check("rst_strobes", 64'({mem_rden, mem_wren}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_grant_addr", 64'({grant_id, mem_addr}), 64'd0);

        // Release into contention: core0 first, core1 after core0 drops.
        reset = 1'b1;
        t0 = cyc;
        sb.push_back('{2'b01, D_A1, t0 + 4, "rr0"});
        sb.push_back('{2'b10, D_A2, t0 + 9, "rr1"});
        step();
        check("rr0_grant", 64'(grant_id), 64'd0);
        check("rr0_issue", 64'({mem_rden, mem_addr}), 64'({1'b1, 4'h1}));
        steps(3);
        rq_rden = 2'b10;
        steps(2);
        check("rr1_issue_cycle", 64'({mem_rden, grant_id, mem_addr}), 64'({1'b1, 1'b1, 4'h2}));
        steps(3);
        rq_rden = 2'b00;
        step();

        do_single(1'b0, 1'b1, 1'b0, 4'h3, 32'h0, D_BE, "rd0");
        do_single(1'b0, 1'b1, 1'b1, 4'h2, 32'hCAFE_F00D, D_BE, "rdwr0");
        do_single(1'b1, 1'b0, 1'b1, 4'h7, 32'h1234_5678, D_BE, "wr1");

        // Sustained contention: grants alternate 0,1,0,1; data reads back the earlier writes.
        t0 = cyc;
        rq0_addr = 4'h2;
        rq1_addr = 4'h7;
        rq_rden  = 2'b11;
        for (int i = 0; i < 4; i++)
            sb.push_back('{i[0] ? 2'b10 : 2'b01, i[0] ? 32'h1234_5678 : 32'hCAFE_F00D,
                           t0 + 4 + 5 * i, i[0] ? "sus1" : "sus0"});
        step();
        for (int i = 0; i < 3; i++) begin
            check("sus_grant", 64'({grant_id, mem_rden}), 64'({i[0], 1'b1}));
            steps(5);
        end
        check("sus_grant_last", 64'({grant_id, mem_rden}), 64'({1'b1, 1'b1}));
        steps(3);
        rq_rden = 2'b00;
        step();

        // Leave rr_ptr pointing at core1 so the post-reset grant proves it was cleared.
        do_single(1'b0, 1'b1, 1'b0, 4'h3, 32'h0, D_BE, "rd0b");

        // Core1 read aborted by reset in WAIT.
        rq1_addr = 4'h1;
        rq_rden  = 2'b10;
        steps(2);
        check("abort_in_wait", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_async_busy", 64'(busy), 64'd0);
        check("abort_async_out", 64'({rq_ack, mem_rden, mem_wren, grant_id, mem_addr}), 64'd0);
        check("abort_async_rdata", 64'(rsp_rdata), 64'd0);
        steps(3);
        rq0_addr = 4'h3;
        rq_rden  = 2'b11;
        reset    = 1'b1;
        t0 = cyc;
        sb.push_back('{2'b01, D_BE, t0 + 4, "post0"});
        sb.push_back('{2'b10, D_A1, t0 + 9, "post1"});
        step();
        check("post_rst_grant", 64'({grant_id, mem_addr}), 64'({1'b0, 4'h3}));
        steps(3);
        rq_rden = 2'b10;
        steps(5);
        rq_rden = 2'b00;
        steps(3);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
